datapath_sequencer: RTL and testbench

Multi-cycle command sequencer for the register-file / ALU / 256x64 RAM datapath. It accepts one decoded command at a time over a valid/ready handshake. It then drives the regfile read/write addresses, ALU function, operand mux, RAM write enable and write-back source select over a fixed state sequence. It sits between instruction decode and the datapath, and is the only block allowed to assert regfile `write` or RAM `writeRam`.

---
 rtl/datapath_sequencer.sv | 177 +++++++++++++++++
 tb/tb_datapath_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: multi-cycle command sequencer for the regfile/ALU/RAM
// datapath. Accepts one command in IDLE, then walks EXEC/MEM/WB/DONE while
// driving registered datapath controls decoded from the captured command.
module datapath_sequencer #(
  parameter int RAM_WAIT = 2
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [1:0] i_cmd_op,
  input  logic [4:0] i_cmd_rd,
  input  logic [4:0] i_cmd_ra,
  input  logic [4:0] i_cmd_rb,
  input  logic [5:0] i_cmd_fn,
  input  logic       i_cmd_cin,
  input  logic [5:0] i_cmd_imm,
  input  logic       i_cmd_use_imm,
  input  logic       i_status_in,
  output logic [4:0] o_readA,
  output logic [4:0] o_readB,
  output logic [4:0] o_writeReg,
  output logic       o_write,
  output logic [5:0] o_sel,
  output logic       o_cin,
  output logic       o_muxSel,
  output logic [5:0] o_imm,
  output logic       o_writeRam,
  output logic       o_wbSel,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_status_q
);

  // A wait of 0 is meaningless for the negedge-registered RAM read; clamp to 1.
  localparam int RW_EFF = (RAM_WAIT < 1) ? 1 : RAM_WAIT;
  localparam int CW     = (RW_EFF > 1) ? $clog2(RW_EFF) : 1;

  localparam logic [1:0] OP_ALU   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MEM, S_WB, S_DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_op;
  logic [4:0]      r_rd, r_ra, r_rb;
  logic [5:0]      r_fn, r_imm;
  logic            r_cin, r_use_imm;
  logic            r_status_q;
  logic            r_cmd_ready, r_busy, r_done, r_write, r_writeRam, r_wbSel;
  logic            r_cin_o, r_muxSel;
  logic [4:0]      r_readA, r_readB, r_writeReg;
  logic [5:0]      r_sel, r_imm_o;

  state_t          w_nxt_state;
  logic [CW-1:0]   w_nxt_cnt;
  logic            w_accept;
  logic [1:0]      w_op;
  logic [4:0]      w_rd, w_ra, w_rb;
  logic [5:0]      w_fn, w_imm;
  logic            w_cin, w_use_imm;
  logic            w_active, w_store;
  logic            w_nxt_status_q;

  // Next state and the command that will be in force in that state.
  always_comb begin
    w_accept    = i_cmd_valid && (r_state == S_IDLE);
    w_op        = w_accept ? i_cmd_op      : r_op;
    w_rd        = w_accept ? i_cmd_rd      : r_rd;
    w_ra        = w_accept ? i_cmd_ra      : r_ra;
    w_rb        = w_accept ? i_cmd_rb      : r_rb;
    w_fn        = w_accept ? i_cmd_fn      : r_fn;
    w_cin       = w_accept ? i_cmd_cin     : r_cin;
    w_imm       = w_accept ? i_cmd_imm     : r_imm;
    w_use_imm   = w_accept ? i_cmd_use_imm : r_use_imm;
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    case (r_state)
      S_IDLE: if (w_accept) w_nxt_state = S_EXEC;
      S_EXEC: begin
        case (r_op)
          OP_ALU:   w_nxt_state = S_WB;
          OP_LOAD:  begin w_nxt_state = S_MEM; w_nxt_cnt = CW'(RW_EFF - 1); end
          OP_STORE: w_nxt_state = S_MEM;
          default:  w_nxt_state = S_DONE;
        endcase
      end
      S_MEM: begin
        if (r_op == OP_STORE)  w_nxt_state = S_DONE;
        else if (r_cnt == '0) w_nxt_state = S_WB;
        else                  w_nxt_cnt   = r_cnt - CW'(1);
      end
      S_WB:    w_nxt_state = S_DONE;
      S_DONE:  w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
    w_active = (w_nxt_state == S_EXEC) || (w_nxt_state == S_MEM) || (w_nxt_state == S_WB);
    w_store  = (w_op == OP_STORE);
    // Status is sampled on the edge leaving EXEC, so it reflects this command's ALU op.
    w_nxt_status_q = ((r_state == S_EXEC) && (r_op != OP_NOP)) ? i_status_in : r_status_q;
  end

  // State, captured command and registered outputs; reset aborts everything at once.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op        <= '0;
      r_rd        <= '0;
      r_ra        <= '0;
      r_rb        <= '0;
      r_fn        <= '0;
      r_cin       <= 1'b0;
      r_imm       <= '0;
      r_use_imm   <= 1'b0;
      r_status_q  <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_write     <= 1'b0;
      r_writeRam  <= 1'b0;
      r_wbSel     <= 1'b0;
      r_readA     <= '0;
      r_readB     <= '0;
      r_writeReg  <= '0;
      r_sel       <= '0;
      r_cin_o     <= 1'b0;
      r_muxSel    <= 1'b0;
      r_imm_o     <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      r_op        <= w_op;
      r_rd        <= w_rd;
      r_ra        <= w_ra;
      r_rb        <= w_rb;
      r_fn        <= w_fn;
      r_cin       <= w_cin;
      r_imm       <= w_imm;
      r_use_imm   <= w_use_imm;
      r_status_q  <= w_nxt_status_q;
      r_cmd_ready <= (w_nxt_state == S_IDLE);
      r_busy      <= (w_nxt_state != S_IDLE);
      r_done      <= (w_nxt_state == S_DONE);
      r_write     <= (w_nxt_state == S_WB);
      r_writeRam  <= (w_nxt_state == S_MEM) && w_store;
      r_wbSel     <= (w_nxt_state == S_WB) && (w_op == OP_LOAD);
      r_writeReg  <= (w_nxt_state == S_WB) ? w_rd : 5'd0;
      // STORE reads the data register on port A and always addresses via the immediate.
      r_readA     <= w_active ? (w_store ? w_rd : w_ra) : 5'd0;
      r_readB     <= w_active ? w_rb : 5'd0;
      r_sel       <= w_active ? w_fn : 6'd0;
      r_cin_o     <= w_active && w_cin;
      r_muxSel    <= w_active && (w_store || w_use_imm);
      r_imm_o     <= w_active ? w_imm : 6'd0;
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_write     = r_write;
  assign o_writeRam  = r_writeRam;
  assign o_wbSel     = r_wbSel;
  assign o_status_q  = r_status_q;
  assign o_readA     = r_readA;
  assign o_readB     = r_readB;
  assign o_writeReg  = r_writeReg;
  assign o_sel       = r_sel;
  assign o_cin       = r_cin_o;
  assign o_muxSel    = r_muxSel;
  assign o_imm       = r_imm_o;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: directed scenarios plus randomized commands
// checked cycle by cycle against a timeline model built from op latencies.
module tb_datapath_sequencer;
  localparam int RW = 2;

  logic       i_clock, i_reset, i_cmd_valid, i_cmd_cin, i_cmd_use_imm, i_status_in;
  logic [1:0] i_cmd_op;
  logic [4:0] i_cmd_rd, i_cmd_ra, i_cmd_rb;
  logic [5:0] i_cmd_fn, i_cmd_imm;
  logic       o_cmd_ready, o_write, o_cin, o_muxSel, o_writeRam, o_wbSel, o_busy, o_done, o_status_q;
  logic [4:0] o_readA, o_readB, o_writeReg;
  logic [5:0] o_sel, o_imm;

  int total = 0;
  int bad   = 0;

  datapath_sequencer #(.RAM_WAIT(RW)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_op(i_cmd_op), .i_cmd_rd(i_cmd_rd), .i_cmd_ra(i_cmd_ra), .i_cmd_rb(i_cmd_rb),
    .i_cmd_fn(i_cmd_fn), .i_cmd_cin(i_cmd_cin), .i_cmd_imm(i_cmd_imm), .i_cmd_use_imm(i_cmd_use_imm),
    .i_status_in(i_status_in), .o_readA(o_readA), .o_readB(o_readB), .o_writeReg(o_writeReg),
    .o_write(o_write), .o_sel(o_sel), .o_cin(o_cin), .o_muxSel(o_muxSel), .o_imm(o_imm),
    .o_writeRam(o_writeRam), .o_wbSel(o_wbSel), .o_busy(o_busy), .o_done(o_done), .o_status_q(o_status_q)
  );

  // all outputs in one vector: ready,busy,done,write,writeRam,wbSel,status_q,readA,readB,writeReg,sel,cin,muxSel,imm
  logic [35:0] outs;
  assign outs = {o_cmd_ready, o_busy, o_done, o_write, o_writeRam, o_wbSel, o_status_q,
                 o_readA, o_readB, o_writeReg, o_sel, o_cin, o_muxSel, o_imm};
  localparam logic [35:0] RST_OUTS = 36'h8_0000_0000;

  // datapath-control view: readA,readB,sel,cin,muxSel,imm
  logic [23:0] ctl;
  assign ctl = {o_readA, o_readB, o_sel, o_cin, o_muxSel, o_imm};

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got=running exp=finished");
    $fatal(1);
  end

  // model: cycle (after the accept edge) in which done is high
  function automatic int done_at(input logic [1:0] op);
    case (op)
      2'b00:   return 3;
      2'b01:   return 3 + RW;
      2'b10:   return 3;
      default: return 2;
    endcase
  endfunction

  task automatic send(input logic [1:0] op, input logic [4:0] rd, ra, rb, input logic [5:0] fn,
                      input logic cin, input logic [5:0] imm, input logic use_imm);
    @(negedge i_clock);
    i_cmd_op = op; i_cmd_rd = rd; i_cmd_ra = ra; i_cmd_rb = rb; i_cmd_fn = fn;
    i_cmd_cin = cin; i_cmd_imm = imm; i_cmd_use_imm = use_imm; i_cmd_valid = 1'b1;
    @(posedge i_clock);
    #1 i_cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    total++; if (outs !== RST_OUTS) begin bad++; $display("FAIL reset_in_reset got=%h exp=%h", outs, RST_OUTS); end
    @(negedge i_clock) i_reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clock);
      total++; if (outs !== RST_OUTS) begin bad++; $display("FAIL reset_idle c%0d got=%h exp=%h", c, outs, RST_OUTS); end
    end
    send(2'b00, 5'd3, 5'd1, 5'd2, 6'h04, 1'b1, 6'd0, 1'b0);
    @(negedge i_clock); @(negedge i_clock);
    total++; if (o_write !== 1'b1) begin bad++; $display("FAIL reset_pre_write got=%b exp=1", o_write); end
    #1 i_reset = 1'b1;
    #1;
    total++; if ({o_cmd_ready, o_busy, o_write, o_writeRam} !== 4'b1000) begin
      bad++; $display("FAIL reset_async got=%b exp=1000", {o_cmd_ready, o_busy, o_write, o_writeRam}); end
    @(negedge i_clock) i_reset = 1'b0;
    @(negedge i_clock);
    total++; if (outs !== RST_OUTS) begin bad++; $display("FAIL reset_after_abort got=%h exp=%h", outs, RST_OUTS); end
  endtask

  task automatic test_alu;
    send(2'b00, 5'd3, 5'd1, 5'd2, 6'h04, 1'b1, 6'd0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge i_clock);
      total++; if (o_write !== (k == 2)) begin bad++; $display("FAIL alu_write c%0d got=%b exp=%b", k, o_write, k == 2); end
      total++; if (o_done !== (k == 3)) begin bad++; $display("FAIL alu_done c%0d got=%b exp=%b", k, o_done, k == 3); end
      total++; if (o_cmd_ready !== (k == 4)) begin bad++; $display("FAIL alu_ready c%0d got=%b exp=%b", k, o_cmd_ready, k == 4); end
      if (k <= 2) begin
        total++; if ({o_sel, o_cin} !== {6'h04, 1'b1}) begin bad++; $display("FAIL alu_sel_cin c%0d got=%h/%b exp=04/1", k, o_sel, o_cin); end
      end
      if (k == 2) begin
        total++; if ({o_writeReg, o_wbSel} !== {5'd3, 1'b0}) begin bad++; $display("FAIL alu_wb c%0d got=%0d/%b exp=3/0", k, o_writeReg, o_wbSel); end
      end
    end
  endtask

  task automatic test_load;
    send(2'b01, 5'd7, 5'd4, 5'd6, 6'h11, 1'b0, 6'h05, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge i_clock);
      total++; if (o_write !== (k == 4)) begin bad++; $display("FAIL load_write c%0d got=%b exp=%b", k, o_write, k == 4); end
      total++; if (o_wbSel !== (k == 4)) begin bad++; $display("FAIL load_wbsel c%0d got=%b exp=%b", k, o_wbSel, k == 4); end
      total++; if (o_done !== (k == 5)) begin bad++; $display("FAIL load_done c%0d got=%b exp=%b", k, o_done, k == 5); end
      total++; if (o_writeRam !== 1'b0) begin bad++; $display("FAIL load_writeram c%0d got=%b exp=0", k, o_writeRam); end
      if (k <= 4) begin
        total++; if ({o_readA, o_readB, o_sel, o_muxSel} !== {5'd4, 5'd6, 6'h11, 1'b1}) begin
          bad++; $display("FAIL load_stable c%0d got=%0d/%0d/%h/%b exp=4/6/11/1", k, o_readA, o_readB, o_sel, o_muxSel); end
      end
      if (k == 4) begin
        total++; if (o_writeReg !== 5'd7) begin bad++; $display("FAIL load_writereg got=%0d exp=7", o_writeReg); end
      end
    end
  endtask

  task automatic test_store;
    send(2'b10, 5'd5, 5'd0, 5'd9, 6'h00, 1'b0, 6'h2A, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge i_clock);
      total++; if (o_writeRam !== (k == 2)) begin bad++; $display("FAIL store_writeram c%0d got=%b exp=%b", k, o_writeRam, k == 2); end
      total++; if (o_write !== 1'b0) begin bad++; $display("FAIL store_write c%0d got=%b exp=0", k, o_write); end
      total++; if (o_done !== (k == 3)) begin bad++; $display("FAIL store_done c%0d got=%b exp=%b", k, o_done, k == 3); end
      if (k <= 2) begin
        total++; if ({o_readA, o_readB, o_muxSel, o_imm} !== {5'd5, 5'd9, 1'b1, 6'h2A}) begin
          bad++; $display("FAIL store_ctl c%0d got=%0d/%0d/%b/%h exp=5/9/1/2a", k, o_readA, o_readB, o_muxSel, o_imm); end
      end
    end
  endtask

  task automatic test_back_to_back;
    @(negedge i_clock);
    i_cmd_op = 2'b11; i_cmd_rd = 5'd0; i_cmd_ra = 5'd0; i_cmd_rb = 5'd0; i_cmd_fn = 6'd0;
    i_cmd_cin = 1'b0; i_cmd_imm = 6'd0; i_cmd_use_imm = 1'b0; i_cmd_valid = 1'b1;
    @(posedge i_clock);
    #1 i_cmd_op = 2'b00; i_cmd_rd = 5'd10; i_cmd_ra = 5'd11; i_cmd_rb = 5'd12; i_cmd_fn = 6'h3F;
    for (int k = 1; k <= 7; k++) begin
      @(negedge i_clock);
      total++; if (o_cmd_ready !== (k == 3 || k == 7)) begin bad++; $display("FAIL b2b_ready c%0d got=%b exp=%b", k, o_cmd_ready, k == 3 || k == 7); end
      total++; if (o_done !== (k == 2 || k == 6)) begin bad++; $display("FAIL b2b_done c%0d got=%b exp=%b", k, o_done, k == 2 || k == 6); end
      total++; if (o_write !== (k == 5)) begin bad++; $display("FAIL b2b_write c%0d got=%b exp=%b", k, o_write, k == 5); end
      if (k == 5) begin
        total++; if (o_writeReg !== 5'd10) begin bad++; $display("FAIL b2b_writereg got=%0d exp=10", o_writeReg); end
      end
      if (k == 4) i_cmd_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid_load;
    send(2'b01, 5'd12, 5'd1, 5'd2, 6'h01, 1'b0, 6'd0, 1'b0);
    @(negedge i_clock) i_status_in = 1'b1;
    @(negedge i_clock);
    total++; if (o_status_q !== 1'b1) begin bad++; $display("FAIL rml_status_captured got=%b exp=1", o_status_q); end
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL rml_busy_mem got=%b exp=1", o_busy); end
    #1 i_reset = 1'b1;
    #1;
    total++; if (outs !== RST_OUTS) begin bad++; $display("FAIL rml_async got=%h exp=%h", outs, RST_OUTS); end
    @(negedge i_clock) i_reset = 1'b0; i_status_in = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clock);
      total++; if ({o_write, o_done, o_cmd_ready} !== 3'b001) begin
        bad++; $display("FAIL rml_quiet c%0d got=%b exp=001", c, {o_write, o_done, o_cmd_ready}); end
    end
    send(2'b11, 5'd0, 5'd0, 5'd0, 6'd0, 1'b0, 6'd0, 1'b0);
    for (int k = 1; k <= 2; k++) begin
      @(negedge i_clock);
      total++; if (o_done !== (k == 2)) begin bad++; $display("FAIL rml_next_done c%0d got=%b exp=%b", k, o_done, k == 2); end
    end
    total++; if (o_status_q !== 1'b0) begin bad++; $display("FAIL rml_status_q got=%b exp=0", o_status_q); end
  endtask

  task automatic test_random;
    logic        exp_sq;
    logic [1:0]  op;
    logic [4:0]  rd, ra, rb;
    logic [5:0]  fn, imm;
    logic        cin, use_imm, st, ld, wr;
    logic [23:0] exp_ctl;
    int          d;
    exp_sq = 1'b0;
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3)); rd = 5'($urandom); ra = 5'($urandom); rb = 5'($urandom);
      fn = 6'($urandom); imm = 6'($urandom); cin = 1'($urandom); use_imm = 1'($urandom);
      st = (op == 2'b10); ld = (op == 2'b01); wr = (op == 2'b00) || ld;
      d  = done_at(op);
      send(op, rd, ra, rb, fn, cin, imm, use_imm);
      for (int k = 1; k <= d + 1; k++) begin
        @(negedge i_clock);
        total++; if ({o_cmd_ready, o_busy, o_done} !== {k == d + 1, k <= d, k == d}) begin
          bad++; $display("FAIL rnd_hs n%0d op%0d c%0d got=%b exp=%b", n, op, k, {o_cmd_ready, o_busy, o_done}, {k == d + 1, k <= d, k == d}); end
        total++; if ({o_write, o_wbSel, o_writeRam} !== {wr && k == d - 1, ld && k == d - 1, st && k == 2}) begin
          bad++; $display("FAIL rnd_wr n%0d op%0d c%0d got=%b exp=%b", n, op, k, {o_write, o_wbSel, o_writeRam}, {wr && k == d - 1, ld && k == d - 1, st && k == 2}); end
        if (wr && k == d - 1) begin
          total++; if (o_writeReg !== rd) begin bad++; $display("FAIL rnd_writereg n%0d got=%0d exp=%0d", n, o_writeReg, rd); end
        end
        if (k >= d) begin
          total++; if ({ctl, o_writeReg} !== 29'd0) begin bad++; $display("FAIL rnd_ctl_zero n%0d c%0d got=%h exp=0", n, k, {ctl, o_writeReg}); end
        end else if (op != 2'b11) begin
          exp_ctl = {st ? rd : ra, rb, fn, cin, st | use_imm, imm};
          total++; if (ctl !== exp_ctl) begin bad++; $display("FAIL rnd_ctl n%0d op%0d c%0d got=%h exp=%h", n, op, k, ctl, exp_ctl); end
        end
        total++; if (o_status_q !== exp_sq) begin bad++; $display("FAIL rnd_status n%0d c%0d got=%b exp=%b", n, k, o_status_q, exp_sq); end
        i_status_in = 1'($urandom);
        if (k == 1 && op != 2'b11) exp_sq = i_status_in;
      end
    end
  endtask

  initial begin
    i_reset = 1'b1; i_cmd_valid = 1'b0; i_status_in = 1'b0;
    i_cmd_op = 2'd0; i_cmd_rd = 5'd0; i_cmd_ra = 5'd0; i_cmd_rb = 5'd0;
    i_cmd_fn = 6'd0; i_cmd_cin = 1'b0; i_cmd_imm = 6'd0; i_cmd_use_imm = 1'b0;
    test_reset;
    test_alu;
    test_load;
    test_store;
    test_back_to_back;
    test_reset_mid_load;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
